// File: rtl/count_15.sv
// Free-running modulo-2**WIDTH up-counter (count15 with defaults); q is the state register itself.
// Latency: one edge from reset release to first increment; no handshake, never stalls.
module count_15 #(
  parameter int unsigned          WIDTH     = 4,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] q
);

  // Reset wins over counting; the carry out of the top bit is simply dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_count_15.sv
// Directed table of {reset, expected q} per edge plus a reference counter and mid-cycle reset sequences.
module tb_count_15;

  logic       clk;
  logic       reset;
  logic [3:0] q;

  int passed;
  int total;

  logic [3:0] model_q;

  typedef struct {
    logic       rst;
    logic [3:0] exp;
    byte        tag;
  } vec_t;

  vec_t vecs[$];

  count_15 dut (
    .clk   (clk),
    .reset (reset),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got === want) begin
      passed++;
    end else begin
      $display("FAIL %s: q=%0h expected %0h", name, got, want);
    end
  endtask

  function automatic void add(input logic rst, input logic [3:0] exp, input byte tag);
    vec_t v;
    v.rst = rst;
    v.exp = exp;
    v.tag = tag;
    vecs.push_back(v);
  endfunction

  // Drive reset on the falling edge, sample 1 unit after the rising edge.
  task automatic step(input logic rst, input logic [3:0] exp, input byte tag);
    @(negedge clk);
    reset = rst;
    @(posedge clk);
    #1;
    model_q = rst ? 4'd0 : model_q + 4'd1;
    check($sformatf("vec_T%0d", tag), q, exp);
    check($sformatf("model_T%0d", tag), q, model_q);
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    reset   = 1'b0;
    model_q = 4'd0;

    // T1: reset for two edges
    add(1'b1, 4'd0, 1);
    add(1'b1, 4'd0, 1);
    // T2: 1..15
    for (int i = 1; i <= 15; i++) add(1'b0, 4'(i), 2);
    // T3: wrap to 0
    add(1'b0, 4'd0, 3);
    // T4: run to 5, reset one edge, run to 5 again
    for (int i = 1; i <= 5; i++) add(1'b0, 4'(i), 4);
    add(1'b1, 4'd0, 4);
    for (int i = 1; i <= 5; i++) add(1'b0, 4'(i), 4);
    // T5: reset held three edges, then first free edge gives 1
    for (int i = 0; i < 3; i++) add(1'b1, 4'd0, 5);
    add(1'b0, 4'd1, 5);
    // T6: run to 15, reset at terminal count, then 1
    for (int i = 2; i <= 15; i++) add(1'b0, 4'(i), 6);
    add(1'b1, 4'd0, 6);
    add(1'b0, 4'd1, 6);

    foreach (vecs[i]) step(vecs[i].rst, vecs[i].exp, vecs[i].tag);

    // Count up to 3, then raise reset between edges: q must hold until the next posedge.
    step(1'b0, 4'd2, 7);
    step(1'b0, 4'd3, 7);
    @(negedge clk);
    reset = 1'b1;
    #2;
    check("async_assert_hold", q, 4'd3);
    @(posedge clk);
    #1;
    model_q = 4'd0;
    check("sync_reset_edge", q, 4'd0);

    // Release reset between edges: q stays 0 until the next posedge, then 1.
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("async_release_hold", q, 4'd0);
    @(posedge clk);
    #1;
    model_q = model_q + 4'd1;
    check("first_count_after_release", q, 4'd1);
    check("model_after_release", q, model_q);

    // Full 16-edge lap from 1 must land back on 1.
    for (int i = 0; i < 16; i++) step(1'b0, 4'((i + 2) % 16), 8);
    check("full_lap", q, 4'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, passed=%0d total=%0d", passed, total);
    $fatal(1, "timeout");
  end

endmodule
